// File: rtl/i2c_codec_responder.sv
// I2C write-only target standing in for the audio codec control port; accepts 3-byte register frames.
// Optional shadow register array enabled by defining I2C_RESPONDER_SHADOW_EN.
module i2c_codec_responder #(
   parameter logic [6:0] DEV_ADDR     = 7'h1A,
   parameter int         SHADOW_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       I2C_SCLK,
   inout  wire        I2C_SDAT,
   output logic       frame_valid,
   output logic [6:0] reg_addr,
   output logic [8:0] reg_data,
   output logic [7:0] frame_count,
   output logic       busy,
   output logic       err,
   input  logic [3:0] rd_addr,
   output logic [8:0] rd_data
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
   } state_t;

   state_t     state_q, state_d;
   logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_prev_q, scl_prev_d;
   logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_prev_q, sda_prev_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] byte1_q, byte1_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       ack_hold_q, ack_hold_d;
   logic       sda_oe_q, sda_oe_d;
   logic       frame_valid_q, frame_valid_d;
   logic       err_q, err_d;
   logic [6:0] reg_addr_q, reg_addr_d;
   logic [8:0] reg_data_q, reg_data_d;
   logic [7:0] frame_count_q, frame_count_d;

   logic scl_rise, scl_fall, start_det, stop_det, addr_acked;

   assign scl_rise  = scl_s2_q & ~scl_prev_q;
   assign scl_fall  = ~scl_s2_q & scl_prev_q;
   assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
   assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;

   // A frame counts as started once the address ACK is actually being driven.
   assign addr_acked = (state_q == BYTE1) || (state_q == ACK_1) || (state_q == BYTE2) ||
                       (state_q == ACK_2) || ((state_q == ACK_A) && ack_hold_q);

   always_comb begin
      scl_s1_d      = I2C_SCLK;
      scl_s2_d      = scl_s1_q;
      scl_prev_d    = scl_s2_q;
      sda_s1_d      = I2C_SDAT;
      sda_s2_d      = sda_s1_q;
      sda_prev_d    = sda_s2_q;
      state_d       = state_q;
      shift_d       = shift_q;
      byte1_d       = byte1_q;
      bit_cnt_d     = bit_cnt_q;
      ack_hold_d    = ack_hold_q;
      sda_oe_d      = sda_oe_q;
      frame_valid_d = 1'b0;
      err_d         = 1'b0;
      reg_addr_d    = reg_addr_q;
      reg_data_d    = reg_data_q;
      frame_count_d = frame_count_q;

      if (start_det) begin
         state_d    = ADDR;
         bit_cnt_d  = 3'd0;
         sda_oe_d   = 1'b0;
         ack_hold_d = 1'b0;
         err_d      = addr_acked;
      end else if (stop_det) begin
         state_d    = IDLE;
         sda_oe_d   = 1'b0;
         ack_hold_d = 1'b0;
         err_d      = addr_acked;
      end else if ((state_q == ADDR || state_q == BYTE1 || state_q == BYTE2) && scl_rise) begin
         shift_d   = {shift_q[6:0], sda_s2_q};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            ack_hold_d = 1'b0;
            if (state_q == ADDR)
               state_d = (shift_d == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
            else if (state_q == BYTE1) begin
               state_d = ACK_1;
               byte1_d = shift_d;
            end else
               state_d = ACK_2;
         end
      end else if ((state_q == ACK_A || state_q == ACK_1 || state_q == ACK_2) && scl_fall) begin
         // First falling edge starts driving the ACK, the second one ends it.
         if (!ack_hold_q) begin
            sda_oe_d   = 1'b1;
            ack_hold_d = 1'b1;
         end else begin
            sda_oe_d   = 1'b0;
            ack_hold_d = 1'b0;
            bit_cnt_d  = 3'd0;
            if (state_q == ACK_A)
               state_d = BYTE1;
            else if (state_q == ACK_1)
               state_d = BYTE2;
            else begin
               state_d       = IGNORE;
               reg_addr_d    = byte1_q[7:1];
               reg_data_d    = {byte1_q[0], shift_q};
               frame_valid_d = 1'b1;
               frame_count_d = frame_count_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         scl_s1_q      <= 1'b1;
         scl_s2_q      <= 1'b1;
         scl_prev_q    <= 1'b1;
         sda_s1_q      <= 1'b1;
         sda_s2_q      <= 1'b1;
         sda_prev_q    <= 1'b1;
         shift_q       <= 8'd0;
         byte1_q       <= 8'd0;
         bit_cnt_q     <= 3'd0;
         ack_hold_q    <= 1'b0;
         sda_oe_q      <= 1'b0;
         frame_valid_q <= 1'b0;
         err_q         <= 1'b0;
         reg_addr_q    <= 7'd0;
         reg_data_q    <= 9'd0;
         frame_count_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         scl_s1_q      <= scl_s1_d;
         scl_s2_q      <= scl_s2_d;
         scl_prev_q    <= scl_prev_d;
         sda_s1_q      <= sda_s1_d;
         sda_s2_q      <= sda_s2_d;
         sda_prev_q    <= sda_prev_d;
         shift_q       <= shift_d;
         byte1_q       <= byte1_d;
         bit_cnt_q     <= bit_cnt_d;
         ack_hold_q    <= ack_hold_d;
         sda_oe_q      <= sda_oe_d;
         frame_valid_q <= frame_valid_d;
         err_q         <= err_d;
         reg_addr_q    <= reg_addr_d;
         reg_data_q    <= reg_data_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign I2C_SDAT    = sda_oe_q ? 1'b0 : 1'bz;
   assign frame_valid = frame_valid_q;
   assign reg_addr    = reg_addr_q;
   assign reg_data    = reg_data_q;
   assign frame_count = frame_count_q;
   assign err         = err_q;
   assign busy        = !((state_q == IDLE) || (state_q == IGNORE));

`ifdef I2C_RESPONDER_SHADOW_EN
   localparam int AW = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;

   logic [8:0] shadow_q [SHADOW_DEPTH];

   // Written from the freshly latched outputs, one clk after the frame_valid pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SHADOW_DEPTH; i++)
            shadow_q[i] <= 9'd0;
      end else if (frame_valid_q && (int'(reg_addr_q) < SHADOW_DEPTH)) begin
         shadow_q[reg_addr_q[AW-1:0]] <= reg_data_q;
      end
   end

   assign rd_data = (int'(rd_addr) < SHADOW_DEPTH) ? shadow_q[rd_addr[AW-1:0]] : 9'd0;
`else
   logic unused_shadow;
   assign unused_shadow = (^rd_addr) ^ (SHADOW_DEPTH > 0);
   assign rd_data       = 9'd0;
`endif

endmodule

// File: doc/i2c_codec_responder.md
Name: i2c_codec_responder

Overview:
- I2C target (responder) modelling the audio codec's control port: the far end of the codec initialization sequence.
- Receives 3-byte write frames: device address + W, then a 16-bit word split as 7-bit register address and 9-bit register data.
- ACKs each byte by pulling I2C_SDAT low, decodes the register write, and reports it to the fabric.
- Serves as the on-chip codec stand-in for bench/loopback checking of the initializer and of any later control-port master.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address (write byte 8'h34).
- SHADOW_DEPTH, 16, shadow register entries; only used with the optional feature.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- reset  input  1  asynchronous, active-low reset.
- I2C_SCLK  input  1  I2C clock from master.
- I2C_SDAT  inout  1  I2C data; this block only ever drives 0 or Z.
- frame_valid  output  1  one-clk pulse when a complete 3-byte write is accepted.
- reg_addr  output  7  register address of the last accepted frame.
- reg_data  output  9  register data of the last accepted frame.
- frame_count  output  8  number of accepted frames; wraps 255->0.
- busy  output  1  high from START until STOP or IGNORE entry.
- err  output  1  one-clk pulse when a frame aborts after the address was ACKed.
- rd_addr  input  4  shadow read address (optional feature).
- rd_data  output  9  shadow read data (optional feature).

Behaviour:
- Input conditioning: 2-flop synchronizer on I2C_SCLK and I2C_SDAT, plus a previous-value register; all edge and START/STOP detection uses synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both take priority over bit sampling in the same clk.
- Bit sampling: on SCL rising edge, MSB first, into an 8-bit shift register; 3-bit bit_cnt 0..7.
- States:
  - IDLE.
  - ADDR, ACK_A.
  - BYTE1, ACK_1.
  - BYTE2, ACK_2.
  - IGNORE.
- IDLE -> ADDR on START; bit_cnt cleared.
- After the 8th bit of a byte, move to the ACK_x state.
- ACK drive timing: on the next SCL falling edge, set sda_oe=1. Hold it through the ACK bit. Clear it on the following SCL falling edge, then continue to the next state.
- ADDR accept: shift == {DEV_ADDR, 1'b0}. Any other value (wrong address, or R/W=1) -> no ACK, go to IGNORE.
- ACK_1 -> BYTE2.
- ACK_2 completion:
  - Latch reg_addr = byte1[7:1] and reg_data = {byte1[0], byte2}.
  - Pulse frame_valid for one clk; frame_count increments in the same clk.
  - Next state IGNORE: further bytes are NACKed.
- IGNORE: sda_oe stays 0 until START or STOP.
- Repeated START in any state: go to ADDR, discard the partial frame, no frame_valid.
  - If the address had already been ACKed and ACK_2 had not completed, also pulse err.
- STOP in any state: go to IDLE and clear sda_oe; same err rule as repeated START.
- I2C_SDAT = sda_oe ? 1'b0 : 1'bz.
- busy = state not in {IDLE, IGNORE}.
- Reset, asynchronous and effective immediately including mid-ACK:
  - state=IDLE, sda_oe=0 (bus released).
  - Synchronizers = 1.
  - frame_valid=0, err=0, reg_addr=0, reg_data=0, frame_count=0.
- Latency: frame_valid asserts 3-4 clk after the SCL falling edge that ends the third ACK, due to synchronizer plus edge register.

Optional Feature:
- Macro: I2C_RESPONDER_SHADOW_EN.
- Defined:
  - SHADOW_DEPTH x 9-bit register array; entry reg_addr[3:0] is written on frame_valid.
  - Frames with reg_addr >= SHADOW_DEPTH are still reported but not stored.
  - rd_data = shadow[rd_addr], combinational read.
  - All entries reset to 0.
- Not defined: no array; rd_data tied to 9'd0; rd_addr ignored.

Test Plan:
- START, 8'h34 8'h00 8'h97, STOP -> ACK low on all 3 ACK bits; frame_valid 1 clk; reg_addr=7'h00, reg_data=9'h097; frame_count=1.
- START, 8'h36 ... -> SDA never driven low; no frame_valid; busy drops on IGNORE entry; frame_count unchanged.
- Ten back-to-back codec init frames (register addresses 0x00..0x09, e.g. 8'h34 8'h12 8'h01 -> reg_addr 7'h09, data 9'h001) -> 10 frame_valid pulses; frame_count=10. With SHADOW_EN, rd_addr=9 gives rd_data=9'h001.
- START, 8'h34 8'h0E, STOP -> 2 ACKs, err pulse, no frame_valid; reg_addr/reg_data keep prior values.
- Reset asserted while sda_oe=1 during the address ACK -> I2C_SDAT is Z in the same cycle; state IDLE; next full frame is accepted normally.
- 256 valid frames -> frame_count wraps to 0 and the 257th frame gives 1.
